// File: rtl/adpll_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// adpll_cfg_ctrl
// Configuration and acquisition controller for the ADPLL core.
//  - Synchronizes the slow pad-level program/clear commands (2-FF + rising-edge
//    detect) and commits writes into the parameter register bank.
//  - Sequences loop start-up (IDLE -> LOAD -> ACQUIRE -> LOCKED).
//  - Runs the lock detector on the qualified phase-error magnitude stream.
//
// Ports:
//   i_clk        sampling clock
//   i_rst        asynchronous, active-high reset
//   i_program    async pad level, rising edge commits one write
//   i_clr        async pad level, rising edge restores defaults and stops loop
//   i_param_sel  register index (0 kp, 1 ki, 2 dco_init, 3 div_n,
//                4 lock_thr, 5 lock_cnt, 6 ctrl, 7 reserved)
//   i_pgm_value  write data
//   i_err_mag    phase-error magnitude
//   i_err_valid  strobe qualifying i_err_mag
//   o_kp, o_ki   loop filter gains
//   o_dco_init   DCO preset word
//   o_div_n      feedback divider ratio
//   o_pll_en     loop enable (ACQUIRE or LOCKED)
//   o_filt_clr   filter/integrator clear (LOAD)
//   o_dco_load   DCO preset load strobe (LOAD)
//   o_locked     lock indicator
//   o_wr_ack     one-cycle pulse per accepted write
// -----------------------------------------------------------------------------
module adpll_cfg_ctrl #(
   parameter int W        = 5,
   parameter int MISS_MAX = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_program,
   input  logic         i_clr,
   input  logic [2:0]   i_param_sel,
   input  logic [W-1:0] i_pgm_value,
   input  logic [W-1:0] i_err_mag,
   input  logic         i_err_valid,
   output logic [W-1:0] o_kp,
   output logic [W-1:0] o_ki,
   output logic [W-1:0] o_dco_init,
   output logic [W-1:0] o_div_n,
   output logic         o_pll_en,
   output logic         o_filt_clr,
   output logic         o_dco_load,
   output logic         o_locked,
   output logic         o_wr_ack
);

   // Hit counter is wide enough for the largest target (31 * 4 = 124).
   localparam int HW = W + 2;
   localparam int MW = $clog2(MISS_MAX + 1);

   localparam logic [W-1:0] KP_DEF  = W'(4);
   localparam logic [W-1:0] KI_DEF  = W'(1);
   localparam logic [W-1:0] DCO_DEF = W'(16);
   localparam logic [W-1:0] DIV_DEF = W'(8);
   localparam logic [W-1:0] THR_DEF = W'(2);
   localparam logic [W-1:0] CNT_DEF = W'(8);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_ACQ    = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   logic          r_prog_s1, r_prog_s2, r_prog_d;
   logic          r_clr_s1, r_clr_s2, r_clr_d;
   logic [W-1:0]  r_kp, r_ki, r_dco_init, r_div_n, r_lock_thr, r_lock_cnt;
   logic          r_run;
   state_t        r_state, w_next;
   logic          r_load_cnt;
   logic [HW-1:0] r_hit_cnt;
   logic [MW-1:0] r_miss_cnt;
   logic          r_pll_en, r_filt_clr, r_dco_load, r_locked, r_wr_ack;

   logic          w_prog_rise, w_clr_rise, w_wr, w_run_off, w_restart;
   logic          w_hit, w_miss;
   logic [HW-1:0] w_target;
   logic [HW:0]   w_hit_next;
   logic [MW:0]   w_miss_next;
   logic          w_pll_en, w_load, w_locked;

   // Pad-level synchronizers and edge-detect history; cleared by reset so no
   // stale edge can commit after reset release.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prog_s1 <= 1'b0;
         r_prog_s2 <= 1'b0;
         r_prog_d  <= 1'b0;
         r_clr_s1  <= 1'b0;
         r_clr_s2  <= 1'b0;
         r_clr_d   <= 1'b0;
      end else begin
         r_prog_s1 <= i_program;
         r_prog_s2 <= r_prog_s1;
         r_prog_d  <= r_prog_s2;
         r_clr_s1  <= i_clr;
         r_clr_s2  <= r_clr_s1;
         r_clr_d   <= r_clr_s2;
      end
   end

   assign w_prog_rise = r_prog_s2 & ~r_prog_d;
   assign w_clr_rise  = r_clr_s2 & ~r_clr_d;
   // clr wins over a coincident program edge; index 7 is discarded.
   assign w_wr        = w_prog_rise & ~w_clr_rise & (i_param_sel != 3'd7);
   assign w_run_off   = w_wr & (i_param_sel == 3'd6) & ~i_pgm_value[0];
   assign w_restart   = w_wr & ((i_param_sel == 3'd2) | (i_param_sel == 3'd3)) &
                        (r_state != S_IDLE);

   assign w_hit       = i_err_valid & (i_err_mag <= r_lock_thr);
   assign w_miss      = i_err_valid & (i_err_mag > r_lock_thr);
   assign w_target    = {((r_lock_cnt == '0) ? W'(1) : r_lock_cnt), 2'b00};
   assign w_hit_next  = {1'b0, r_hit_cnt} + {{HW{1'b0}}, 1'b1};
   assign w_miss_next = {1'b0, r_miss_cnt} + {{MW{1'b0}}, 1'b1};

   // Parameter register bank: reset/clr load defaults, commits write one entry.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_kp       <= KP_DEF;
         r_ki       <= KI_DEF;
         r_dco_init <= DCO_DEF;
         r_div_n    <= DIV_DEF;
         r_lock_thr <= THR_DEF;
         r_lock_cnt <= CNT_DEF;
         r_run      <= 1'b0;
         r_wr_ack   <= 1'b0;
      end else begin
         r_wr_ack <= w_wr;
         if (w_clr_rise) begin
            r_kp       <= KP_DEF;
            r_ki       <= KI_DEF;
            r_dco_init <= DCO_DEF;
            r_div_n    <= DIV_DEF;
            r_lock_thr <= THR_DEF;
            r_lock_cnt <= CNT_DEF;
            r_run      <= 1'b0;
         end else if (w_wr) begin
            case (i_param_sel)
               3'd0:    r_kp       <= i_pgm_value;
               3'd1:    r_ki       <= i_pgm_value;
               3'd2:    r_dco_init <= i_pgm_value;
               3'd3:    r_div_n    <= i_pgm_value;
               3'd4:    r_lock_thr <= i_pgm_value;
               3'd5:    r_lock_cnt <= i_pgm_value;
               3'd6:    r_run      <= i_pgm_value[0];
               default: r_run      <= r_run;
            endcase
         end else begin
            r_run <= r_run;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // FSM next-state logic; command overrides take priority over loop progress.
   always_comb begin
      w_next = r_state;
      if (w_clr_rise || w_run_off) begin
         w_next = S_IDLE;
      end else if (w_restart) begin
         w_next = S_LOAD;
      end else begin
         case (r_state)
            S_IDLE:   w_next = r_run ? S_LOAD : S_IDLE;
            S_LOAD:   w_next = r_load_cnt ? S_ACQ : S_LOAD;
            S_ACQ:    w_next = (w_hit && (w_hit_next >= {1'b0, w_target})) ?
                               S_LOCKED : S_ACQ;
            S_LOCKED: w_next = (w_miss && (w_miss_next >= (MW+1)'(MISS_MAX))) ?
                               S_ACQ : S_LOCKED;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // LOAD duration and lock-detector counters; each is zero outside the state
   // that uses it, so every entry into LOAD/IDLE/ACQUIRE starts from zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_load_cnt <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_load_cnt <= (r_state == S_LOAD) && (w_next == S_LOAD) && !w_restart;

         if ((r_state != S_ACQ) || (w_next != S_ACQ)) r_hit_cnt <= '0;
         else if (w_hit)                              r_hit_cnt <= w_hit_next[HW-1:0];
         else if (w_miss)                             r_hit_cnt <= '0;
         else                                         r_hit_cnt <= r_hit_cnt;

         if ((r_state != S_LOCKED) || (w_next != S_LOCKED)) r_miss_cnt <= '0;
         else if (w_miss)                                   r_miss_cnt <= w_miss_next[MW-1:0];
         else if (w_hit)                                    r_miss_cnt <= '0;
         else                                               r_miss_cnt <= r_miss_cnt;
      end
   end

   // FSM output decode from the next state so registered flags align with state.
   always_comb begin
      w_pll_en = (w_next == S_ACQ) || (w_next == S_LOCKED);
      w_load   = (w_next == S_LOAD);
      w_locked = (w_next == S_LOCKED);
   end

   // Output flag registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pll_en   <= 1'b0;
         r_filt_clr <= 1'b0;
         r_dco_load <= 1'b0;
         r_locked   <= 1'b0;
      end else begin
         r_pll_en   <= w_pll_en;
         r_filt_clr <= w_load;
         r_dco_load <= w_load;
         r_locked   <= w_locked;
      end
   end

   assign o_kp       = r_kp;
   assign o_ki       = r_ki;
   assign o_dco_init = r_dco_init;
   assign o_div_n    = r_div_n;
   assign o_pll_en   = r_pll_en;
   assign o_filt_clr = r_filt_clr;
   assign o_dco_load = r_dco_load;
   assign o_locked   = r_locked;
   assign o_wr_ack   = r_wr_ack;

endmodule

// File: tb/tb_adpll_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adpll_cfg_ctrl
// Self-checking bench: a behavioural model of the controller (register map,
// edge timing, mode/countdown/hit-miss tallies) is stepped at every clock edge
// and compared against the DUT on every falling edge. Directed sequences pin the
// model with hand-computed literals, then randomized writes, clears and
// error streams exercise the rest.
// -----------------------------------------------------------------------------
module tb_adpll_cfg_ctrl;
   localparam int W        = 5;
   localparam int MISS_MAX = 2;
   localparam int MI = 0, ML = 1, MA = 2, MK = 3;

   logic         clk = 1'b0;
   logic         rst, pgm, clr;
   logic [2:0]   sel;
   logic [W-1:0] val, mag;
   logic         vld;
   logic [W-1:0] kp, ki, dco, div;
   logic         pll_en, filt_clr, dco_load, locked, wr_ack;

   int checks   = 0;
   int failures = 0;

   // error stream source: 0 none, 1 fixed magnitude every cycle, 2 random
   int           err_mode = 0;
   logic [W-1:0] dir_mag  = '0;
   logic         rnd_vld  = 1'b0;
   logic [W-1:0] rnd_mag  = '0;

   assign vld = (err_mode == 1) ? 1'b1 : (err_mode == 2) ? rnd_vld : 1'b0;
   assign mag = (err_mode == 2) ? rnd_mag : dir_mag;

   adpll_cfg_ctrl #(.W(W), .MISS_MAX(MISS_MAX)) dut (
      .i_clk(clk), .i_rst(rst), .i_program(pgm), .i_clr(clr),
      .i_param_sel(sel), .i_pgm_value(val), .i_err_mag(mag), .i_err_valid(vld),
      .o_kp(kp), .o_ki(ki), .o_dco_init(dco), .o_div_n(div),
      .o_pll_en(pll_en), .o_filt_clr(filt_clr), .o_dco_load(dco_load),
      .o_locked(locked), .o_wr_ack(wr_ack)
   );

   initial forever #5 clk = ~clk;

   // random error samples, refreshed away from the active edge
   always @(posedge clk) begin
      #2;
      rnd_vld = ($urandom_range(0, 3) != 0);
      rnd_mag = ($urandom_range(0, 4) != 0) ? W'($urandom_range(0, 3)) :
                                              W'($urandom_range(0, 31));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_kp, m_ki, m_dco, m_div, m_thr, m_lcnt, m_run;
   int m_mode, m_left, m_hits, m_miss, m_ack;
   bit ph0, ph1, ph2, ch0, ch1, ch2;   // pad levels seen at the last three edges

   task automatic m_defaults();
      m_kp = 4; m_ki = 1; m_dco = 16; m_div = 8; m_thr = 2; m_lcnt = 8; m_run = 0;
      m_mode = MI; m_left = 0; m_hits = 0; m_miss = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_defaults();
         m_ack = 0;
         ph0 = 0; ph1 = 0; ph2 = 0; ch0 = 0; ch1 = 0; ch2 = 0;
      end else begin
         bit commit, clr_e, hit;
         int target, prev;
         // a level first seen high two edges ago, low three edges ago, commits now
         commit = ph1 && !ph2;
         clr_e  = ch1 && !ch2;
         ph2 = ph1; ph1 = ph0; ph0 = pgm;
         ch2 = ch1; ch1 = ch0; ch0 = clr;
         m_ack = 0;
         if (clr_e) begin
            m_defaults();
         end else begin
            prev   = m_mode;
            target = ((m_lcnt == 0) ? 1 : m_lcnt) * 4;
            hit    = vld && (int'(mag) <= m_thr);
            case (m_mode)
               MI: if (m_run != 0) begin m_mode = ML; m_left = 2; end
               ML: begin
                  m_left--;
                  if (m_left == 0) begin m_mode = MA; m_hits = 0; end
               end
               MA: if (vld) begin
                  if (hit) begin
                     m_hits++;
                     if (m_hits >= target) begin m_mode = MK; m_miss = 0; end
                  end else m_hits = 0;
               end
               MK: if (vld) begin
                  if (!hit) begin
                     m_miss++;
                     if (m_miss >= MISS_MAX) begin m_mode = MA; m_hits = 0; m_miss = 0; end
                  end else m_miss = 0;
               end
               default: m_mode = MI;
            endcase
            if (commit && sel != 3'd7) begin
               m_ack = 1;
               case (sel)
                  3'd0: m_kp = val;
                  3'd1: m_ki = val;
                  3'd2: m_dco = val;
                  3'd3: m_div = val;
                  3'd4: m_thr = val;
                  3'd5: m_lcnt = val;
                  default: m_run = val[0];
               endcase
               if (sel == 3'd6 && !val[0]) m_mode = MI;
               else if ((sel == 3'd2 || sel == 3'd3) && prev != MI) begin
                  m_mode = ML; m_left = 2;
               end
            end
         end
      end
   end

   // every-cycle comparison of DUT against the model
   always @(negedge clk) begin
      check("kp", kp, m_kp);
      check("ki", ki, m_ki);
      check("dco_init", dco, m_dco);
      check("div_n", div, m_div);
      check("pll_en", pll_en, (m_mode == MA || m_mode == MK) ? 1 : 0);
      check("filt_clr", filt_clr, (m_mode == ML) ? 1 : 0);
      check("dco_load", dco_load, (m_mode == ML) ? 1 : 0);
      check("locked", locked, (m_mode == MK) ? 1 : 0);
      check("wr_ack", wr_ack, m_ack);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // returns 2 ns after the commit edge
   task automatic do_write(input logic [2:0] s, input logic [W-1:0] v);
      sel = s; val = v;
      @(posedge clk); #2 pgm = 1'b1;
      repeat (3) @(posedge clk);
      #2 pgm = 1'b0;
   endtask

   task automatic feed(input logic [W-1:0] m, input int n);
      dir_mag = m; err_mode = 1;
      repeat (n) @(posedge clk);
      #2 err_mode = 0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #2 clr = 1'b1;
      repeat (3) @(posedge clk);
      #2 clr = 1'b0;
      cyc(3);
   endtask

   initial begin
      rst = 1'b1; pgm = 1'b0; clr = 1'b0; sel = '0; val = '0;
      cyc(3);
      check("rst_kp", kp, 4);
      check("rst_ki", ki, 1);
      check("rst_dco", dco, 16);
      check("rst_div", div, 8);
      check("rst_flags", {pll_en, filt_clr, dco_load, locked, wr_ack}, 0);
      rst = 1'b0;
      cyc(2);

      // basic write, single ack
      do_write(3'd0, 5'd9);
      check("wr_kp", kp, 9);
      check("wr_ack_hi", wr_ack, 1);
      cyc(1);
      check("wr_ack_lo", wr_ack, 0);
      cyc(2);
      // reserved index: no change, no ack
      do_write(3'd7, 5'd21);
      check("rsv_ack", wr_ack, 0);
      check("rsv_kp", kp, 9);
      check("rsv_div", div, 8);
      cyc(3);

      // start loop: 2-cycle LOAD then pll_en
      do_write(3'd6, 5'd1);
      check("run_c_filt", filt_clr, 0);
      cyc(1);
      check("load1", {filt_clr, dco_load, pll_en}, 3'b110);
      cyc(1);
      check("load2", {filt_clr, dco_load, pll_en}, 3'b110);
      cyc(1);
      check("acq_en", {filt_clr, dco_load, pll_en}, 3'b001);
      // miss on sample 20 restarts the count; lock after 32 clean hits
      feed(5'd1, 19);
      feed(5'd5, 1);
      feed(5'd1, 31);
      check("lock_31", locked, 0);
      feed(5'd1, 1);
      check("lock_32", locked, 1);
      // single miss then hit keeps lock; two consecutive misses drop it
      feed(5'd5, 1);
      feed(5'd1, 1);
      feed(5'd5, 1);
      check("one_miss", locked, 1);
      feed(5'd5, 1);
      check("unlock", {locked, pll_en}, 2'b01);
      feed(5'd1, 32);
      check("relock", locked, 1);

      // divider write while locked restarts LOAD
      do_write(3'd3, 5'd12);
      check("div_wr", div, 12);
      check("div_load", {locked, filt_clr, pll_en}, 3'b010);
      cyc(1);
      check("div_load2", filt_clr, 1);
      cyc(1);
      check("div_acq", {filt_clr, pll_en}, 2'b01);
      feed(5'd1, 32);
      check("div_relock", locked, 1);
      cyc(3);

      // coincident clr and program: clr wins, write dropped
      sel = 3'd0; val = 5'd3;
      @(posedge clk); #2 pgm = 1'b1; clr = 1'b1;
      repeat (3) @(posedge clk);
      #2 pgm = 1'b0; clr = 1'b0;
      check("coin_ack", wr_ack, 0);
      check("coin_kp", kp, 4);
      check("coin_div", div, 8);
      check("coin_flags", {pll_en, locked}, 0);
      cyc(3);

      // async reset during the second LOAD cycle
      do_write(3'd6, 5'd1);
      cyc(2);
      check("pre_rst_load", filt_clr, 1);
      #1 rst = 1'b1;
      #1 check("async_rst", {pll_en, filt_clr, dco_load, locked, wr_ack}, 0);
      @(posedge clk); #2 rst = 1'b0;
      cyc(4);
      check("post_rst_idle", {pll_en, filt_clr}, 0);

      // randomized writes, clears and error stream
      err_mode = 2;
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 15) == 0) begin
            pulse_clr();
         end else begin
            logic [2:0]   s;
            logic [W-1:0] v;
            s = 3'($urandom_range(0, 7));
            v = W'($urandom_range(0, 31));
            if (s == 3'd6) v[0] = ($urandom_range(0, 3) != 0);
            if (s == 3'd5) v = W'($urandom_range(0, 3));
            do_write(s, v);
            cyc(3);
         end
         cyc($urandom_range(0, 30));
      end
      err_mode = 0;
      cyc(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adpll_cfg_ctrl.md
# adpll_cfg_ctrl

Configuration and acquisition controller for the 5-bit ADPLL core. It turns the slow pad-level program/clear commands into a synchronized parameter register bank (loop gains, DCO preset, divider ratio, lock criteria), sequences loop start-up (filter clear and DCO preload), and runs the lock detector on the phase-error stream. It sits between the top-level pad wrapper and the ADPLL datapath, and is clocked by the sampling clock.

## Interface
Parameters:
- W, 5, width of parameter values and the phase-error magnitude
- MISS_MAX, 2, consecutive out-of-window samples that drop lock

Ports:
- clk  in  1  sampling clock
- rst  in  1  asynchronous, active-high reset
- program  in  1  async pad level; a rising edge commits one write
- clr  in  1  async pad level; a rising edge restores defaults and stops the loop
- param_sel  in  3  register index, sampled at the commit cycle
- pgm_value  in  W  write data, sampled at the commit cycle
- err_mag  in  W  phase-error magnitude from the TDC/ACS path
- err_valid  in  1  one-cycle strobe qualifying err_mag
- kp, ki  out  W  proportional / integral gain to the loop filter
- dco_init  out  W  DCO preset word
- div_n  out  W  feedback divider ratio
- pll_en  out  1  loop enable (state is ACQUIRE or LOCKED)
- filt_clr  out  1  filter/integrator clear
- dco_load  out  1  DCO preset load strobe
- locked  out  1  lock indicator
- wr_ack  out  1  one-cycle pulse per accepted write

## Operation
- program and clr each pass through a 2-FF synchronizer followed by a rising-edge detector.
- Commit cycle: the cycle in which the program edge is detected.
- param_sel and pgm_value are sampled raw at the commit cycle. They must be stable from 1 cycle before program rises until 3 cycles after it rises.
- Register map and defaults (also the reset values):
  - 0 kp = 4
  - 1 ki = 1
  - 2 dco_init = 16
  - 3 div_n = 8
  - 4 lock_thr = 2
  - 5 lock_cnt = 8
  - 6 ctrl = 0 (bit0 run; bits 4:1 reserved, read as 0)
  - 7 is reserved: a write to it is discarded and gives no wr_ack.
- Writes to registers 0–6 take effect at the commit edge, and wr_ack pulses in the same cycle.
- A clr edge loads all defaults and forces IDLE. If clr and program edges fall in the same cycle, clr wins and the write is dropped with no wr_ack.
- FSM states: IDLE, LOAD, ACQUIRE, LOCKED.
  - IDLE: all strobes low. Go to LOAD when ctrl.run = 1.
  - LOAD: exactly 2 cycles with filt_clr = 1 and dco_load = 1, then go to ACQUIRE.
  - ACQUIRE: a sample hits when err_valid = 1 and err_mag <= lock_thr. Each hit increments the 7-bit hit counter. A miss (err_valid = 1, err_mag > lock_thr) clears it. When the counter reaches target = max(lock_cnt,1) × 4, go to LOCKED.
  - LOCKED: locked = 1. A miss increments the miss counter and a hit clears it. When the miss counter reaches MISS_MAX, go to ACQUIRE with both counters cleared.
- From any running state (LOAD, ACQUIRE, LOCKED):
  - a write with ctrl.run = 0 goes to IDLE;
  - a write to dco_init or div_n goes back to LOAD, which restarts the 2-cycle count;
  - writes to kp, ki, lock_thr or lock_cnt apply live with no state change. A lowered target is compared on the next hit.
- err_valid is ignored in IDLE and LOAD. All counters are cleared on entry to LOAD and IDLE.

## Timing
- Reset: registers at defaults, state IDLE, and pll_en, filt_clr, dco_load, locked, wr_ack all 0.
- Outputs are registered; state-derived outputs change the cycle after the transition edge.
- Write latency: if program is sampled high at edge k, the commit is at edge k+2. The updated register and wr_ack are visible after edge k+2.
- ctrl.run written at edge c: LOAD from c+1, filt_clr and dco_load high for cycles c+1 and c+2, pll_en high from c+3.
- Lock latency: with target T and one hit per cycle, locked rises one cycle after the T-th hit.
- Unlock: locked falls one cycle after the MISS_MAX-th consecutive miss.
- An asynchronous rst mid-LOAD or mid-write clears everything immediately. A pending synchronized edge must not commit after reset releases, so the synchronizers are reset to 0.
- The program and clr levels must each be held at least 2 cycles high and 2 cycles low to be seen as a single edge.

## Test plan
- Reset, then read outputs → kp=4, ki=1, dco_init=16, div_n=8, all flags 0, state IDLE.
- Write sel=0, value=9 (program high at edge 10) → kp=9 after edge 12, a single wr_ack pulse. Write sel=7 → no register changes, no wr_ack.
- Write ctrl=1 → filt_clr and dco_load high for exactly 2 cycles, then pll_en=1. Feed err_mag=1 every cycle with lock_cnt=8 → locked rises after the 32nd hit. A miss at hit 20 restarts the count.
- In LOCKED, feed two consecutive err_mag=5 samples → locked drops and the state is ACQUIRE. A single miss followed by a hit keeps lock.
- While locked, write div_n=12 → state LOAD, locked=0, 2-cycle clear, then re-acquire. Make clr and program edges coincide → defaults restored, IDLE, no wr_ack.
- Assert rst during the second LOAD cycle → all outputs 0 asynchronously. After release, ctrl.run=0 and state stays IDLE.
